fp_mul_seq: RTL and testbench

- Multi-cycle IEEE-754 double-precision multiplier. It is the responder side of the single-pulse `valid`/`finish` operator handshake that the CMU_* compute FSMs drive.
- CMU FSMs instantiate it as their shared multiplier: they pulse `valid` with `a`/`b` applied and wait for the one-cycle `finish` pulse.
- Latency is fixed, so initiators can rely on a deterministic schedule.
- It trades area for latency with an iterative radix-2^BITS_PER_CYCLE mantissa multiply.

---
 rtl/fp_mul_seq.sv | 201 ++++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - multi-cycle IEEE-754 binary64 multiplier with valid/finish handshake
// Define FP_MUL_EXCEPT_EN to add flags output {invalid, overflow, underflow, inexact}.
module fp_mul_seq #(
  parameter int DBL_WIDTH      = 64,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [DBL_WIDTH-1:0] a,
  input  logic [DBL_WIDTH-1:0] b,
  output logic                 finish,
  output logic [DBL_WIDTH-1:0] result,
  output logic                 busy
`ifdef FP_MUL_EXCEPT_EN
  ,
  output logic [3:0]           flags
`endif
);
  localparam int ITER = (53 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  state_t               state, state_next;
  logic                 accept;

  logic [DBL_WIDTH-1:0] op_a, op_b;
  logic                 sign;
  logic signed [12:0]   exp_r;
  special_t             special, special_next;
  logic [105:0]         mcand, acc, chunk;
  logic [52:0]          mplier, mant;
  logic [CW-1:0]        cnt;
  logic                 g_bit, r_bit, s_bit;

  logic [10:0]          ea, eb;
  logic [51:0]          fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  logic                 round_up;
  logic [53:0]          mant_rnd;
  logic signed [12:0]   exp_fin;
  logic [51:0]          frac_out;
  logic                 ovf, unf;
  logic [DBL_WIDTH-1:0] res_word;
`ifdef FP_MUL_EXCEPT_EN
  logic [3:0]           flags_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A valid coinciding with finish is dropped: the unit is still busy that cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (valid && !finish) begin
          accept     = 1'b1;
          state_next = UNPACK;
        end
      end
      UNPACK: state_next = MUL;
      MUL:    if (cnt == CW'(ITER - 1)) state_next = NORM;
      NORM:   state_next = ROUND;
      ROUND:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subnormal operands are classified as zero (flush-to-zero on input).
  always_comb begin
    ea     = op_a[62:52];
    eb     = op_b[62:52];
    fa     = op_a[51:0];
    fb     = op_b[51:0];
    a_zero = (ea == 11'd0);
    b_zero = (eb == 11'd0);
    a_inf  = (ea == 11'h7FF) && (fa == 52'd0);
    b_inf  = (eb == 11'h7FF) && (fb == 52'd0);
    a_nan  = (ea == 11'h7FF) && (fa != 52'd0);
    b_nan  = (eb == 11'h7FF) && (fb != 52'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) special_next = SP_NAN;
    else if (a_inf || b_inf)                                     special_next = SP_INF;
    else if (a_zero || b_zero)                                   special_next = SP_ZERO;
    else                                                         special_next = SP_NONE;
    chunk = {{(106 - BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
  end

  always_comb begin
    round_up = g_bit & (r_bit | s_bit | mant[0]);
    mant_rnd = {1'b0, mant} + {53'd0, round_up};
    exp_fin  = exp_r + $signed({12'd0, mant_rnd[53]});
    frac_out = mant_rnd[53] ? mant_rnd[52:1] : mant_rnd[51:0];
    ovf      = (exp_fin >= 13'sd2047);
    unf      = (exp_fin <= 13'sd0);
    res_word = {sign, exp_fin[10:0], frac_out};
`ifdef FP_MUL_EXCEPT_EN
    flags_word = 4'b0000;
`endif
    case (special)
      SP_NAN: begin
        res_word = 64'h7FF8_0000_0000_0000;
`ifdef FP_MUL_EXCEPT_EN
        flags_word = 4'b1000;
`endif
      end
      SP_INF:  res_word = {sign, 11'h7FF, 52'd0};
      SP_ZERO: res_word = {sign, 63'd0};
      default: begin
        if (ovf)      res_word = {sign, 11'h7FF, 52'd0};
        else if (unf) res_word = {sign, 63'd0};
`ifdef FP_MUL_EXCEPT_EN
        flags_word = {1'b0, ovf, unf & ~ovf, g_bit | r_bit | s_bit | ovf | unf};
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finish  <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      sign    <= 1'b0;
      exp_r   <= '0;
      special <= SP_NONE;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      mant    <= '0;
      cnt     <= '0;
      g_bit   <= 1'b0;
      r_bit   <= 1'b0;
      s_bit   <= 1'b0;
`ifdef FP_MUL_EXCEPT_EN
      flags   <= 4'b0000;
`endif
    end else begin
      finish <= 1'b0;
`ifdef FP_MUL_EXCEPT_EN
      flags  <= 4'b0000;
`endif
      if (accept)      busy <= 1'b1;
      else if (finish) busy <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_a <= a;
            op_b <= b;
          end
        end
        UNPACK: begin
          sign    <= op_a[63] ^ op_b[63];
          exp_r   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 13'sd1023;
          special <= special_next;
          mcand   <= a_zero ? 106'd0 : {53'd0, 1'b1, fa};
          mplier  <= b_zero ? 53'd0 : {1'b1, fb};
          acc     <= '0;
          cnt     <= '0;
        end
        MUL: begin
          acc    <= acc + mcand * chunk;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + CW'(1);
        end
        NORM: begin
          if (acc[105]) begin
            mant  <= acc[105:53];
            g_bit <= acc[52];
            r_bit <= acc[51];
            s_bit <= |acc[50:0];
            exp_r <= exp_r + 13'sd1;
          end else begin
            mant  <= acc[104:52];
            g_bit <= acc[51];
            r_bit <= acc[50];
            s_bit <= |acc[49:0];
          end
        end
        ROUND: begin
          result <= res_word;
          finish <= 1'b1;
`ifdef FP_MUL_EXCEPT_EN
          flags  <= flags_word;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - self-checking bench for fp_mul_seq: vector table, corner sequences, random vs real-arith model
module tb_fp_mul_seq;
  localparam int LAT = 17;

  logic        clk = 1'b0;
  logic        rst_n, valid, finish, busy;
  logic [63:0] a, b, result;
`ifdef FP_MUL_EXCEPT_EN
  logic [3:0]  flags;
`endif

  always #5 clk = ~clk;

  fp_mul_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (valid),
    .a      (a),
    .b      (b),
    .finish (finish),
    .result (result),
    .busy   (busy)
`ifdef FP_MUL_EXCEPT_EN
    ,
    .flags  (flags)
`endif
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_res;
    logic [3:0]  exp_flags;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: specials from the IEEE rules, otherwise the host's double multiply with FTZ on output.
  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
    logic xz, yz, xi, yi, xn, yn, s;
    logic [63:0] p;
    xz = (x[62:52] == 11'd0);
    yz = (y[62:52] == 11'd0);
    xi = (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
    yi = (y[62:52] == 11'h7FF) && (y[51:0] == 52'd0);
    xn = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    yn = (y[62:52] == 11'h7FF) && (y[51:0] != 52'd0);
    s  = x[63] ^ y[63];
    if (xn || yn || (xi && yz) || (xz && yi)) return 64'h7FF8_0000_0000_0000;
    if (xi || yi) return {s, 11'h7FF, 52'd0};
    if (xz || yz) return {s, 63'd0};
    p = $realtobits($bitstoreal(x) * $bitstoreal(y));
    if (p[62:52] == 11'd0) return {s, 63'd0};
    return p;
  endfunction

  function automatic logic [63:0] gen_op();
    logic [63:0] r;
    int sel;
    sel = $urandom_range(0, 11);
    r   = {$urandom(), $urandom()};
    case (sel)
      0: r = {r[63], 63'd0};
      1: r = {r[63], 11'h7FF, 52'd0};
      2: r = {r[63], 11'h7FF, r[51:1], 1'b1};
      3: r = {r[63], 11'd0, r[51:0]};
      default: r = {r[63], 11'($urandom_range(512, 1534)), r[51:0]};
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [63:0] ai, input logic [63:0] bi,
                        output logic [63:0] res, output logic [3:0] flg, output int lat);
    int busy_low;
    valid = 1'b1;
    a     = ai;
    b     = bi;
    @(posedge clk); #1;
    valid    = 1'b0;
    lat      = -1;
    res      = '0;
    flg      = '0;
    busy_low = 0;
    for (int k = 1; k <= 40; k++) begin
      if (!busy) busy_low++;
      @(posedge clk); #1;
      if (finish) begin
        lat = k;
        res = result;
`ifdef FP_MUL_EXCEPT_EN
        flg = flags;
`endif
        break;
      end
    end
    if (!busy) busy_low++;
    check("busy_during_op", 64'(busy_low), 64'd0);
    @(posedge clk); #1;
    check("finish_one_cycle", {63'd0, finish}, 64'd0);
    check("busy_after_finish", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    vec_t        vecs [17];
    logic [63:0] res, x, y;
    logic [3:0]  flg;
    int          lat, nfin, first;
    logic [63:0] fres;

    vecs[0]  = '{64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000, 4'b0000};
    vecs[1]  = '{64'h3FF8000000000000, 64'hBFF8000000000000, 64'hC002000000000000, 4'b0000};
    vecs[2]  = '{64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002, 4'b0001};
    vecs[3]  = '{64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 4'b1000};
    vecs[4]  = '{64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FF0000000000000, 4'b0101};
    vecs[5]  = '{64'h0010000000000000, 64'h0010000000000000, 64'h0000000000000000, 4'b0011};
    vecs[6]  = '{64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 4'b1000};
    vecs[7]  = '{64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 4'b0000};
    vecs[8]  = '{64'h8000000000000000, 64'h4008000000000000, 64'h8000000000000000, 4'b0000};
    vecs[9]  = '{64'h0000000000000001, 64'h4000000000000000, 64'h0000000000000000, 4'b0000};
    vecs[10] = '{64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF8000000000002, 4'b0001};
    vecs[11] = '{64'h3FF0000000000003, 64'h3FF8000000000000, 64'h3FF8000000000004, 4'b0001};
    vecs[12] = '{64'h3FFC000000000000, 64'h3FF2492492492492, 64'h4000000000000000, 4'b0001};
    vecs[13] = '{64'h0010000000000000, 64'h3FE0000000000000, 64'h0000000000000000, 4'b0011};
    vecs[14] = '{64'h3FFFFFFFFFFFFFFF, 64'h3FFFFFFFFFFFFFFF, 64'h400FFFFFFFFFFFFE, 4'b0001};
    vecs[15] = '{64'h7FE0000000000000, 64'h3FF0000000000000, 64'h7FE0000000000000, 4'b0000};
    vecs[16] = '{64'h8000000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 4'b1000};

    rst_n = 1'b0;
    valid = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_finish", {63'd0, finish}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
`ifdef FP_MUL_EXCEPT_EN
    check("reset_flags", {60'd0, flags}, 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, flg, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
`ifdef FP_MUL_EXCEPT_EN
      check($sformatf("vec%0d_flags", i), {60'd0, flg}, {60'd0, vecs[i].exp_flags});
`endif
    end

    // Busy: a second request mid-operation and one in the finish cycle are both dropped.
    valid = 1'b1;
    a     = 64'h4000000000000000;
    b     = 64'h4008000000000000;
    @(posedge clk); #1;
    valid = 1'b0;
    nfin  = 0;
    first = -1;
    fres  = '0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      if (finish) begin
        nfin++;
        if (first < 0) begin
          first = k;
          fres  = result;
        end
        valid = 1'b1;
        a     = 64'h4014000000000000;
        b     = 64'h4014000000000000;
      end
      if (k == 5) begin
        valid = 1'b1;
        a     = 64'h4014000000000000;
        b     = 64'h4014000000000000;
      end
    end
    valid = 1'b0;
    check("busy_finish_count", 64'(nfin), 64'd1);
    check("busy_finish_cycle", 64'(first), 64'(LAT));
    check("busy_result", fres, 64'h4018000000000000);
    run_op(64'h4014000000000000, 64'h4014000000000000, res, flg, lat);
    check("after_busy_latency", 64'(lat), 64'(LAT));
    check("after_busy_result", res, 64'h4039000000000000);

    // Reset mid-operation aborts without a finish.
    valid = 1'b1;
    a     = 64'h4000000000000000;
    b     = 64'h4008000000000000;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_finish", {63'd0, finish}, 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nfin  = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (finish) nfin++;
    end
    check("abort_no_finish", 64'(nfin), 64'd0);
    run_op(64'h3FF8000000000000, 64'h4000000000000000, res, flg, lat);
    check("post_abort_latency", 64'(lat), 64'(LAT));
    check("post_abort_result", res, 64'h4008000000000000);

    for (int i = 0; i < 60; i++) begin
      x = gen_op();
      y = gen_op();
      run_op(x, y, res, flg, lat);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("rand%0d_result %h*%h", i, x, y), res, ref_mul(x, y));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
